// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//
// Counts the pulse train produced by a coin mechanism and turns it into a coin
// code for the vending FSM. 1 pulse = 5 units, 2 pulses = 10 units and
// 4 pulses = 20 units. A train is finished after GAP_CYCLES consecutive
// clock cycles with no rising edge.
//
// Parameters
//   GAP_CYCLES  edge-free cycles that close a pulse train (2..255)
//   SAT_CNT     saturation value of the accepted-coin tally
//
// Ports
//   clk        clock; all state updates on its rising edge
//   rst        asynchronous, active-low reset
//   pulse_in   raw asynchronous pulse line from the coin mechanism
//   accept_en  1 = accept coins, 0 = count them but hand them back
//   coin       registered coin code: 00 none, 01 = 5, 10 = 10, 11 = 20
//   reject     registered one-cycle strobe: valid coin returned
//   err        registered one-cycle strobe: pulse count was not 1, 2 or 4
//   busy       1 while a train is being counted or emitted
//   tally      accepted-coin count, saturating at SAT_CNT
//   dbg_state  current FSM state (0 IDLE, 1 COUNT, 2 EMIT)
//
// The coin/reject/err strobes are always exactly one cycle wide and appear
// in the EMIT cycle only. There is no handshake: the consumer must sample
// the strobes on every clock; nothing is held or retried.
// -----------------------------------------------------------------------------
module coin_acceptor #(
  parameter int GAP_CYCLES = 8,
  parameter int SAT_CNT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       reject,
  output logic       err,
  output logic       busy,
  output logic [7:0] tally,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // gap is compared against GAP_CYCLES-1 because the cycle that sees
  // gap == GAP_CYCLES-1 with no edge is the GAP_CYCLES-th quiet cycle.
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] SAT      = 8'(SAT_CNT);

  state_t     state;
  state_t     state_nx;
  logic       sync1;
  logic       sync2;
  logic       sync3;
  logic       pulse_edge;
  logic [2:0] pcnt;
  logic [2:0] pcnt_nx;
  logic [7:0] gap;
  logic [7:0] gap_nx;
  logic       train_done;
  logic [1:0] code_dec;
  logic [1:0] coin_nx;
  logic       reject_nx;
  logic       err_nx;

  // ---------------------------------------------------------------------------
  // Synchronizer plus edge-detect flop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign pulse_edge = sync2 & ~sync3;

  // The train closes in the last quiet COUNT cycle; EMIT follows next cycle.
  assign train_done = (state == COUNT) && !pulse_edge && (gap == GAP_LAST);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pcnt  <= 3'd0;
      gap   <= 8'd0;
    end else begin
      state <= state_nx;
      pcnt  <= pcnt_nx;
      gap   <= gap_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    gap_nx   = gap;
    case (state)
      IDLE: begin
        pcnt_nx = 3'd0;
        gap_nx  = 8'd0;
        if (pulse_edge) begin
          state_nx = COUNT;
          pcnt_nx  = 3'd1;
        end
      end
      COUNT: begin
        if (pulse_edge) begin
          pcnt_nx = (pcnt == 3'd7) ? 3'd7 : pcnt + 3'd1;
          gap_nx  = 8'd0;
        end else if (gap == GAP_LAST) begin
          state_nx = EMIT;
        end else begin
          gap_nx = gap + 8'd1;
        end
      end
      EMIT: begin
        // An edge landing in the EMIT cycle starts the next train right away
        // so its first pulse is not dropped.
        gap_nx = 8'd0;
        if (pulse_edge) begin
          state_nx = COUNT;
          pcnt_nx  = 3'd1;
        end else begin
          state_nx = IDLE;
          pcnt_nx  = 3'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        pcnt_nx  = 3'd0;
        gap_nx   = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output logic (next values of the registered strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    case (pcnt)
      3'd1:    code_dec = 2'b01;
      3'd2:    code_dec = 2'b10;
      3'd4:    code_dec = 2'b11;
      default: code_dec = 2'b00;
    endcase
  end

  always_comb begin
    coin_nx   = 2'b00;
    reject_nx = 1'b0;
    err_nx    = 1'b0;
    // accept_en matters only in this one cycle, whatever it did during COUNT.
    if (train_done) begin
      if (code_dec == 2'b00) begin
        err_nx = 1'b1;
      end else if (accept_en) begin
        coin_nx = code_dec;
      end else begin
        reject_nx = 1'b1;
      end
    end
  end

  // Output registers: loaded on entry to EMIT, cleared when EMIT ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin   <= 2'b00;
      reject <= 1'b0;
      err    <= 1'b0;
      tally  <= 8'd0;
    end else begin
      coin   <= coin_nx;
      reject <= reject_nx;
      err    <= err_nx;
      if ((state == EMIT) && (coin != 2'b00) && (tally < SAT)) begin
        tally <= tally + 8'd1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//
// Directed bench for coin_acceptor with default parameters (GAP_CYCLES = 8,
// SAT_CNT = 255). Inputs are driven 1 time unit after a rising clock edge
// and outputs are sampled at the same point, well away from the edge.
//
// Timing used throughout: a pulse driven high just after edge N is seen by
// the edge detector in the cycle starting at edge N+2, so the EMIT cycle of
// a train whose last rising pulse was driven at edge N starts at edge
// N + 2 + GAP_CYCLES + 1 = N + 11. send_pulses ends 4 edges after the last
// rising drive, so the strobe is seen on the 7th tick after it returns.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

  logic       clk;
  logic       rst;
  logic       pulse_in;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       err;
  logic       busy;
  logic [7:0] tally;
  logic [1:0] dbg_state;

  int total;
  int bad;

  coin_acceptor #(
    .GAP_CYCLES(8),
    .SAT_CNT   (255)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .accept_en(accept_en),
    .coin     (coin),
    .reject   (reject),
    .err      (err),
    .busy     (busy),
    .tally    (tally),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n pulses, each 2 cycles high then 2 cycles low
  task automatic send_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      tick();
      tick();
      pulse_in = 1'b0;
      tick();
      tick();
    end
  endtask

  // Called right after send_pulses: expects 6 quiet cycles, then one EMIT
  // cycle with the given strobes, then everything idle again.
  task automatic expect_emit(input string tag, input logic [1:0] exp_coin,
                             input logic exp_rej, input logic exp_err,
                             input int exp_tally);
    int early;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (coin != 2'b00 || reject || err) early++;
    end
    check({tag, "_early_strobe"}, early, 0);
    tick();
    check({tag, "_coin"}, int'(coin), int'(exp_coin));
    check({tag, "_reject"}, int'(reject), int'(exp_rej));
    check({tag, "_err"}, int'(err), int'(exp_err));
    check({tag, "_busy_emit"}, int'(busy), 1);
    tick();
    check({tag, "_strobes_clear"}, int'({coin, reject, err}), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_tally"}, int'(tally), exp_tally);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int strobes;
    int coins;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    pulse_in  = 1'b0;
    accept_en = 1'b1;

    // Reset state
    tick();
    tick();
    tick();
    check("reset_coin", int'(coin), 0);
    check("reset_flags", int'({reject, err, busy}), 0);
    check("reset_tally", int'(tally), 0);
    check("reset_state", int'(dbg_state), 0);
    rst = 1'b1;
    tick();
    tick();

    // One pulse, accepted
    send_pulses(1);
    check("one_busy_count", int'(busy), 1);
    expect_emit("one", 2'b01, 1'b0, 1'b0, 1);

    // Two pulses, 20 idle cycles, four pulses
    send_pulses(2);
    expect_emit("two", 2'b10, 1'b0, 1'b0, 2);
    repeat (20) tick();
    send_pulses(4);
    expect_emit("four", 2'b11, 1'b0, 1'b0, 3);
    repeat (5) tick();

    // Three pulses -> error
    send_pulses(3);
    expect_emit("three", 2'b00, 1'b0, 1'b1, 3);
    repeat (5) tick();

    // accept_en = 0, four pulses -> rejected
    accept_en = 1'b0;
    send_pulses(4);
    expect_emit("rej4", 2'b00, 1'b1, 1'b0, 3);
    repeat (5) tick();

    // accept_en low during the count but high when the train closes -> accepted
    accept_en = 1'b0;
    send_pulses(1);
    accept_en = 1'b1;
    expect_emit("en_late", 2'b01, 1'b0, 1'b0, 4);
    repeat (5) tick();

    // Second train's first edge falls in the EMIT cycle of a single pulse
    pulse_in = 1'b1;          // t0
    tick();
    tick();
    pulse_in = 1'b0;
    tick();
    tick();                   // t4
    repeat (5) tick();        // t9
    pulse_in = 1'b1;          // second train, pulse 1
    tick();
    tick();                   // t11: EMIT of the first coin
    check("ovl_first_coin", int'(coin), 1);
    pulse_in = 1'b0;
    tick();
    tick();                   // t13
    pulse_in = 1'b1;          // second train, pulse 2
    tick();
    tick();
    pulse_in = 1'b0;
    tick();
    tick();                   // t17
    expect_emit("ovl_second", 2'b10, 1'b0, 1'b0, 6);
    repeat (5) tick();

    // pulse_in held high: one edge, one coin
    pulse_in = 1'b1;
    coins    = 0;
    strobes  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (coin == 2'b01) coins++;
      if (coin != 2'b00 || reject || err) strobes++;
    end
    check("held_coins", coins, 1);
    check("held_strobes", strobes, 1);
    pulse_in = 1'b0;
    repeat (5) tick();
    check("held_tally", int'(tally), 7);

    // Reset after the first of two pulses
    send_pulses(1);
    check("rst_busy_before", int'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_out", int'({coin, reject, err}), 0);
    check("rst_async_tally", int'(tally), 0);
    check("rst_async_state", int'(dbg_state), 0);
    tick();
    tick();
    rst = 1'b1;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (coin != 2'b00 || reject || err || busy) strobes++;
    end
    check("rst_no_strobe_after", strobes, 0);

    // Saturate the tally at 255 and confirm it holds
    for (int i = 0; i < 255; i++) begin
      send_pulses(1);
      repeat (9) tick();
    end
    check("sat_reach", int'(tally), 255);
    send_pulses(1);
    expect_emit("sat_hold", 2'b01, 1'b0, 1'b0, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
